// File: rtl/hazard_scoreboard_pkg.sv
// Shared core constants for register addressing, used by the scoreboard and the forwarding unit.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]  reg_mask_t;

  // One-hot register mask; the zero register maps to an empty mask so it never hazards.
  function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
    reg_mask_t mask;
    mask = '0;
    if (addr != ZERO_REG) mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Three-stage destination tag shift register (IS/EX/WB) with flush, feeding the forwarding unit.
module hazard_tag_pipe
  import hazard_scoreboard_pkg::*;
(
  input  logic      clock_in,
  input  logic      reset_in,
  input  logic      flush_in,
  input  reg_addr_t new_tag_in,
  output reg_addr_t rd1_addr_out,
  output reg_addr_t rd2_addr_out,
  output reg_addr_t rd3_addr_out
);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      rd1_addr_out <= ZERO_REG;
      rd2_addr_out <= ZERO_REG;
      rd3_addr_out <= ZERO_REG;
    end else if (flush_in) begin
      rd1_addr_out <= ZERO_REG;
      rd2_addr_out <= ZERO_REG;
      rd3_addr_out <= ZERO_REG;
    end else begin
      rd1_addr_out <= new_tag_in;
      rd2_addr_out <= rd1_addr_out;
      rd3_addr_out <= rd2_addr_out;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: tracks in-flight long-latency writes and stalls dependent issues.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  issue_valid_in,
  input  logic [REG_ADDR_W-1:0] issue_rs1_addr_in,
  input  logic [REG_ADDR_W-1:0] issue_rs2_addr_in,
  input  logic [REG_ADDR_W-1:0] issue_rd_addr_in,
  input  logic                  issue_long_in,
  input  logic                  wb_valid_in,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_in,
  input  logic                  flush_in,
  output logic                  stall_out,
  output logic [REG_ADDR_W-1:0] rd1_addr_out,
  output logic [REG_ADDR_W-1:0] rd2_addr_out,
  output logic [REG_ADDR_W-1:0] rd3_addr_out,
  output logic [REG_COUNT-1:0]  pending_out,
  output logic                  busy_out
);

  reg_mask_t pending_q;
  reg_mask_t wb_clear;
  reg_mask_t pend_eff;
  reg_mask_t issue_mask;
  reg_mask_t issue_set;
  reg_addr_t new_tag;
  logic      issue_fire;

  // A same-cycle writeback already resolves its hazard, so it is masked before the stall check.
  always_comb begin
    wb_clear   = wb_valid_in ? reg_onehot(wb_rd_addr_in) : '0;
    pend_eff   = pending_q & ~wb_clear;
    issue_mask = reg_onehot(issue_rs1_addr_in) | reg_onehot(issue_rs2_addr_in)
               | reg_onehot(issue_rd_addr_in);
    stall_out  = issue_valid_in && ((pend_eff & issue_mask) != '0);
    issue_fire = issue_valid_in && !stall_out && !flush_in;
    issue_set  = (issue_fire && issue_long_in) ? reg_onehot(issue_rd_addr_in) : '0;
    new_tag    = (issue_fire && !issue_long_in) ? issue_rd_addr_in : ZERO_REG;
  end

  // Clear is applied before set so a same-cycle reissue to the written-back register keeps its bit.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~wb_clear) | issue_set;
    end
  end

  assign pending_out = pending_q;
  assign busy_out    = (pending_q != '0);

  hazard_tag_pipe u_tag_pipe (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .flush_in     (flush_in),
    .new_tag_in   (new_tag),
    .rd1_addr_out (rd1_addr_out),
    .rd2_addr_out (rd2_addr_out),
    .rd3_addr_out (rd3_addr_out)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector tables, reset corner cases and a randomized model run.
module tb_hazard_scoreboard;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        issue_valid_in = 1'b0;
  logic [4:0]  issue_rs1_addr_in = '0;
  logic [4:0]  issue_rs2_addr_in = '0;
  logic [4:0]  issue_rd_addr_in = '0;
  logic        issue_long_in = 1'b0;
  logic        wb_valid_in = 1'b0;
  logic [4:0]  wb_rd_addr_in = '0;
  logic        flush_in = 1'b0;
  logic        stall_out;
  logic [4:0]  rd1_addr_out, rd2_addr_out, rd3_addr_out;
  logic [31:0] pending_out;
  logic        busy_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit        valid;
    bit [4:0]  rs1, rs2, rd;
    bit        lng;
    bit        wbv;
    bit [4:0]  wbrd;
    bit        flush;
    bit        e_stall;
    bit [31:0] e_pend;
    bit [4:0]  e_rd1, e_rd2, e_rd3;
  } vec_t;

  vec_t vecs[15];
  vec_t seq[6];

  // Reference model state: pending flags per register and a queue of IS/EX/WB tags.
  bit pend_m[32];
  int tag_q[$];

  hazard_scoreboard dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .issue_valid_in    (issue_valid_in),
    .issue_rs1_addr_in (issue_rs1_addr_in),
    .issue_rs2_addr_in (issue_rs2_addr_in),
    .issue_rd_addr_in  (issue_rd_addr_in),
    .issue_long_in     (issue_long_in),
    .wb_valid_in       (wb_valid_in),
    .wb_rd_addr_in     (wb_rd_addr_in),
    .flush_in          (flush_in),
    .stall_out         (stall_out),
    .rd1_addr_out      (rd1_addr_out),
    .rd2_addr_out      (rd2_addr_out),
    .rd3_addr_out      (rd3_addr_out),
    .pending_out       (pending_out),
    .busy_out          (busy_out)
  );

  always #5 clock_in = ~clock_in;

  function automatic vec_t mk(bit v, bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd, bit lng,
                              bit wbv, bit [4:0] wbrd, bit fl, bit e_st, bit [31:0] e_pend,
                              bit [4:0] e1, bit [4:0] e2, bit [4:0] e3);
    vec_t r;
    r.valid = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.lng = lng;
    r.wbv = wbv; r.wbrd = wbrd; r.flush = fl; r.e_stall = e_st; r.e_pend = e_pend;
    r.e_rd1 = e1; r.e_rd2 = e2; r.e_rd3 = e3;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    issue_valid_in    = v.valid;
    issue_rs1_addr_in = v.rs1;
    issue_rs2_addr_in = v.rs2;
    issue_rd_addr_in  = v.rd;
    issue_long_in     = v.lng;
    wb_valid_in       = v.wbv;
    wb_rd_addr_in     = v.wbrd;
    flush_in          = v.flush;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input bit [31:0] e_pend,
                            input bit [4:0] e1, input bit [4:0] e2, input bit [4:0] e3);
    checkOutput({tag, " pending"}, pending_out, e_pend);
    checkOutput({tag, " busy"}, {31'b0, busy_out}, {31'b0, e_pend != 0});
    checkOutput({tag, " rd1"}, {27'b0, rd1_addr_out}, {27'b0, e1});
    checkOutput({tag, " rd2"}, {27'b0, rd2_addr_out}, {27'b0, e2});
    checkOutput({tag, " rd3"}, {27'b0, rd3_addr_out}, {27'b0, e3});
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clock_in);
    applyStimulus(v);
    #1;
    checkOutput({tag, " stall"}, {31'b0, stall_out}, {31'b0, v.e_stall});
    @(posedge clock_in);
    #1;
    check_regs(tag, v.e_pend, v.e_rd1, v.e_rd2, v.e_rd3);
  endtask

  task automatic do_reset();
    @(negedge clock_in);
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    reset_in = 1'b1;
    #1;
    check_regs("reset", 32'h0, 5'd0, 5'd0, 5'd0);
    checkOutput("reset stall", {31'b0, stall_out}, 32'h0);
    @(negedge clock_in);
    reset_in = 1'b0;
    pend_m = '{default: 1'b0};
    tag_q = {0, 0, 0};
  endtask

  function automatic bit model_stall();
    bit eff[32];
    eff = pend_m;
    if (wb_valid_in) eff[wb_rd_addr_in] = 1'b0;
    eff[0] = 1'b0;
    return issue_valid_in && (eff[issue_rs1_addr_in] || eff[issue_rs2_addr_in] || eff[issue_rd_addr_in]);
  endfunction

  task automatic model_step(input bit st);
    bit fire;
    fire = issue_valid_in && !st && !flush_in;
    if (wb_valid_in) pend_m[wb_rd_addr_in] = 1'b0;
    if (fire && issue_long_in) pend_m[issue_rd_addr_in] = 1'b1;
    pend_m[0] = 1'b0;
    if (flush_in) begin
      tag_q = {0, 0, 0};
    end else begin
      tag_q.push_front((fire && !issue_long_in) ? int'(issue_rd_addr_in) : 0);
      void'(tag_q.pop_back());
    end
  endtask

  function automatic bit [31:0] model_pend_vec();
    bit [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = pend_m[i];
    return r;
  endfunction

  initial begin
    vecs[0]  = mk(1,1,2,3,0, 0,0,0, 0,32'h0,   3,0,0);
    vecs[1]  = mk(1,1,2,4,0, 0,0,0, 0,32'h0,   4,3,0);
    vecs[2]  = mk(1,1,2,7,0, 0,0,0, 0,32'h0,   7,4,3);
    vecs[3]  = mk(1,0,0,5,1, 0,0,0, 0,32'h20,  0,7,4);
    vecs[4]  = mk(1,5,0,8,0, 0,0,0, 1,32'h20,  0,0,7);
    vecs[5]  = mk(1,5,0,8,0, 0,0,0, 1,32'h20,  0,0,0);
    vecs[6]  = mk(1,5,0,8,0, 1,5,0, 0,32'h0,   8,0,0);
    vecs[7]  = mk(1,0,0,0,1, 0,0,0, 0,32'h0,   0,8,0);
    vecs[8]  = mk(1,0,0,0,0, 0,0,0, 0,32'h0,   0,0,8);
    vecs[9]  = mk(1,0,0,9,1, 1,9,0, 0,32'h200, 0,0,0);
    vecs[10] = mk(1,1,0,9,1, 0,0,0, 1,32'h200, 0,0,0);
    vecs[11] = mk(1,2,3,9,0, 0,0,0, 1,32'h200, 0,0,0);
    vecs[12] = mk(0,0,0,0,0, 1,0,0, 0,32'h200, 0,0,0);
    vecs[13] = mk(0,0,0,0,0, 1,12,0, 0,32'h200, 0,0,0);
    vecs[14] = mk(0,9,0,0,0, 1,9,0, 0,32'h0,   0,0,0);

    seq[0] = mk(1,0,0,6,1,  0,0,0, 0,32'h40, 0,0,0);
    seq[1] = mk(1,0,0,2,0,  0,0,0, 0,32'h40, 2,0,0);
    seq[2] = mk(1,0,0,3,0,  0,0,0, 0,32'h40, 3,2,0);
    seq[3] = mk(1,0,0,4,0,  0,0,0, 0,32'h40, 4,3,2);
    seq[4] = mk(1,0,0,11,0, 0,0,1, 0,32'h40, 0,0,0);
    seq[5] = mk(0,0,0,0,0,  1,6,0, 0,32'h0,  0,0,0);

    do_reset();
    for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    do_reset();
    for (int i = 0; i < 6; i++) run_vec($sformatf("flush%0d", i), seq[i]);

    // Asynchronous reset between edges must clear state before the next clock.
    do_reset();
    run_vec("arst_setup", mk(1,0,0,8,1, 0,0,0, 0,32'h100, 0,0,0));
    @(negedge clock_in);
    applyStimulus(mk(1,8,0,1,0, 0,0,0, 0,0,0,0,0));
    #1;
    checkOutput("arst pre stall", {31'b0, stall_out}, 32'h1);
    reset_in = 1'b1;
    #1;
    check_regs("arst", 32'h0, 5'd0, 5'd0, 5'd0);
    checkOutput("arst stall", {31'b0, stall_out}, 32'h0);
    @(negedge clock_in);
    reset_in = 1'b0;

    do_reset();
    for (int c = 0; c < 400; c++) begin
      bit st;
      vec_t v;
      @(negedge clock_in);
      v = mk($urandom_range(99) < 70, 5'($urandom_range(7)), 5'($urandom_range(7)),
             5'($urandom_range(7)), $urandom_range(99) < 30, $urandom_range(99) < 35,
             5'($urandom_range(7)), $urandom_range(99) < 5, 0, 0, 0, 0, 0);
      applyStimulus(v);
      #1;
      st = model_stall();
      checkOutput($sformatf("rand%0d stall", c), {31'b0, stall_out}, {31'b0, st});
      model_step(st);
      @(posedge clock_in);
      #1;
      check_regs($sformatf("rand%0d", c), model_pend_vec(),
                 5'(tag_q[0]), 5'(tag_q[1]), 5'(tag_q[2]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
